// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states, grant source
// encoding and the byte-enable pattern used for full-word instruction fetches.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIfBus,
    StMemBus,
    StResp
  } arb_state_e;

  typedef enum logic {
    SrcIf,
    SrcMem
  } arb_src_e;

  localparam logic [3:0] FetchBe = 4'hF;

endpackage

// File: rtl/arb_watchdog.sv
// Bus watchdog: counts cycles while enabled and flags the TIMEOUT-th cycle.
// The counter is cleared (loaded with zero) whenever the arbiter is not in a
// bus state, so each transaction starts from zero.
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;

  // Count bus cycles; hold at the last value instead of wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // High during the TIMEOUT-th cycle spent in a bus state
  assign expired = enable && (cnt_q == LastCnt);

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Arbiter for the single unified memory port shared by the IF and MEM stages.
// One registered bus transaction at a time; a one-cycle done pulse returns the
// read data to the granted stage. MEM has priority (older instruction).
// Optional feature: define PIPE_ARB_STARVE_GUARD_EN to let IF win after
// STARVE_LIMIT consecutive MEM grants made while IF was waiting.
module pipe_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned TIMEOUT      = 15,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [3:0]    mem_be,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_done,
  output logic          mem_stall,
  output logic          bus_req,
  output logic          bus_we,
  output logic [3:0]    bus_be,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack,
  output logic          bus_err
);

  arb_state_e state_q;
  arb_src_e   src_q;
  logic       in_bus;
  logic       wd_expired;
  logic       grant_mem;
  logic       grant_if;

  assign in_bus = (state_q == StIfBus) || (state_q == StMemBus);

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (!in_bus),
    .enable  (in_bus),
    .expired (wd_expired)
  );

`ifdef PIPE_ARB_STARVE_GUARD_EN
  localparam int unsigned StW = $clog2(STARVE_LIMIT + 1);

  logic [StW-1:0] starve_q;
  logic           if_favoured;

  assign if_favoured = if_req && (starve_q == StW'(STARVE_LIMIT));
  assign grant_mem   = mem_req && !if_favoured;
  assign grant_if    = if_req && !grant_mem;

  // Count MEM grants that bypassed a waiting fetch; any IF grant or an
  // uncontended MEM grant restarts the count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else if (state_q == StIdle) begin
      if (grant_mem) begin
        starve_q <= if_req ? starve_q + StW'(1) : '0;
      end else if (grant_if) begin
        starve_q <= '0;
      end
    end
  end
`else
  assign grant_mem = mem_req;
  assign grant_if  = if_req && !mem_req;

  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
`endif

  // Stalls follow the request until the registered done pulse; forced low in reset
  assign if_stall  = reset && if_req && !if_done;
  assign mem_stall = reset && mem_req && !mem_done;

  // Arbitration FSM with registered bus payload, done pulses and read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      src_q     <= SrcIf;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_err   <= 1'b0;
      if_rdata  <= '0;
      if_done   <= 1'b0;
      mem_rdata <= '0;
      mem_done  <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      bus_err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_mem) begin
            state_q   <= StMemBus;
            src_q     <= SrcMem;
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_be    <= mem_be;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
          end else if (grant_if) begin
            state_q   <= StIfBus;
            src_q     <= SrcIf;
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_be    <= FetchBe;
            bus_addr  <= if_addr;
            bus_wdata <= '0;
          end
        end
        StIfBus, StMemBus: begin
          // An ack in the expiring cycle still wins over the timeout
          if (bus_ack || wd_expired) begin
            state_q <= StResp;
            bus_req <= 1'b0;
            bus_err <= !bus_ack;
            if (src_q == SrcIf) begin
              if_done  <= 1'b1;
              if_rdata <= bus_ack ? bus_rdata : '0;
            end else begin
              mem_done  <= 1'b1;
              mem_rdata <= (bus_ack && !bus_we) ? bus_rdata : '0;
            end
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Self-checking bench for pipe_mem_arbiter: a table of single transactions
// with hand-computed timing, plus directed sequences for arbitration ties,
// asynchronous reset mid-transaction and IF starvation.
module tb_pipe_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned STARVE_LIMIT = 4;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          if_stall;
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;
  logic          mem_stall;
  logic          bus_req;
  logic          bus_we;
  logic [3:0]    bus_be;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_ack;
  logic          bus_err;

  pipe_mem_arbiter #(
    .AW           (AW),
    .DW           (DW),
    .TIMEOUT      (TIMEOUT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .if_stall  (if_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .mem_stall (mem_stall),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_be    (bus_be),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One transaction: cycle 0 is the cycle the request is first presented;
  // ack_cyc is the cycle bus_ack is driven high (99 = never)
  typedef struct {
    bit          is_mem;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_cyc;
    logic [31:0] word;
    logic [31:0] exp_rdata;
    int          exp_done;
    int          exp_breq;
    int          exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic do_txn(input int idx, input vec_t v);
    int          done_cyc;
    int          err_cyc;
    int          breq_n;
    logic [31:0] rd;
    bit          pay_ok;
    bit          stall_ok;
    done_cyc = -1;
    err_cyc  = -1;
    breq_n   = 0;
    rd       = '0;
    pay_ok   = 1'b1;
    stall_ok = 1'b1;
    if (v.is_mem) begin
      mem_req   = 1'b1;
      mem_we    = v.we;
      mem_be    = v.be;
      mem_addr  = v.addr;
      mem_wdata = v.wdata;
    end else begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end
    for (int c = 0; c < 40 && done_cyc < 0; c++) begin
      bus_ack   = (c == v.ack_cyc);
      bus_rdata = (c == v.ack_cyc) ? v.word : (32'hBAD0_0000 | 32'(c));
      @(negedge clk);
      if (bus_req) begin
        breq_n++;
        if (bus_addr !== v.addr || bus_we !== (v.is_mem ? v.we : 1'b0) ||
            bus_be !== (v.is_mem ? v.be : 4'hF) || (v.is_mem && bus_wdata !== v.wdata))
          pay_ok = 1'b0;
      end
      if (bus_err) err_cyc = c;
      if (v.is_mem ? mem_done : if_done) begin
        done_cyc = c;
        rd = v.is_mem ? mem_rdata : if_rdata;
      end
      if ((v.is_mem ? mem_stall : if_stall) !== (done_cyc < 0)) stall_ok = 1'b0;
      if ((v.is_mem ? if_done : mem_done) !== 1'b0) stall_ok = 1'b0;
      @(posedge clk);
      #1;
    end
    if_req  = 1'b0;
    mem_req = 1'b0;
    bus_ack = 1'b0;
    check($sformatf("v%0d_done_cycle", idx), 32'(done_cyc), 32'(v.exp_done));
    check($sformatf("v%0d_rdata", idx), rd, v.exp_rdata);
    check($sformatf("v%0d_err_cycle", idx), 32'(err_cyc), 32'(v.exp_err));
    check($sformatf("v%0d_bus_req_cycles", idx), 32'(breq_n), 32'(v.exp_breq));
    check($sformatf("v%0d_payload_stable", idx), 32'(pay_ok), 32'd1);
    check($sformatf("v%0d_stall_done", idx), 32'(stall_ok), 32'd1);
    @(negedge clk);
    check($sformatf("v%0d_single_pulse", idx), 32'({if_done, mem_done, bus_req, bus_err}), 32'd0);
    @(posedge clk);
    #1;
  endtask

  int          md;
  int          id;
  int          n_done;
  int          first_if;
  logic [31:0] a1;
  logic [31:0] a4;
  logic [31:0] mrd;
  logic [31:0] ird;
  logic [1:0]  s2;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h0040_0000, 32'h0, 1, 32'h8C08_0004, 32'h8C08_0004, 2, 1, -1};
    vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h1001_0000, 32'h0, 1, 32'h1234_5678, 32'h1234_5678, 2, 1, -1};
    vecs[2] = '{1'b1, 1'b1, 4'b0011, 32'h1001_0004, 32'hDEAD_BEEF, 4, 32'hCAFE_F00D, 32'h0,
                5, 4, -1};
    vecs[3] = '{1'b1, 1'b0, 4'hF, 32'h1001_000C, 32'h0, 3, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 4, 3, -1};
    vecs[4] = '{1'b0, 1'b0, 4'hF, 32'h0040_0004, 32'h0, 15, 32'h2402_0001, 32'h2402_0001,
                16, 15, -1};
    vecs[5] = '{1'b0, 1'b0, 4'hF, 32'h0040_0008, 32'h0, 99, 32'h1111_2222, 32'h0, 16, 15, 16};
    vecs[6] = '{1'b1, 1'b1, 4'b1000, 32'h1001_0008, 32'h1122_3344, 1, 32'h5555_6666, 32'h0,
                2, 1, -1};

    reset     = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    bus_rdata = '0;
    bus_ack   = 1'b0;
    #3;
    check("reset_ctl", 32'({bus_req, bus_we, bus_be, if_done, mem_done, if_stall, mem_stall,
                            bus_err}), 32'd0);
    check("reset_payload", bus_addr | bus_wdata, 32'd0);
    check("reset_rdata", if_rdata | mem_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) do_txn(i, vecs[i]);

    // Simultaneous requests: MEM first, IF granted in the following IDLE
    mem_req   = 1'b1;
    mem_we    = 1'b0;
    mem_be    = 4'hF;
    mem_addr  = 32'h1001_0000;
    mem_wdata = '0;
    if_req    = 1'b1;
    if_addr   = 32'h0040_0000;
    md = -1;
    id = -1;
    a1 = '0;
    a4 = '0;
    mrd = '0;
    ird = '0;
    s2 = '0;
    for (int c = 0; c < 20 && id < 0; c++) begin
      @(negedge clk);
      bus_ack   = bus_req;
      bus_rdata = ~bus_addr;
      if (c == 1) a1 = bus_addr;
      if (c == 4) a4 = bus_addr;
      if (c == 2) s2 = {if_stall, mem_stall};
      if (mem_done && md < 0) begin
        md  = c;
        mrd = mem_rdata;
      end
      if (if_done) begin
        id  = c;
        ird = if_rdata;
      end
      @(posedge clk);
      #1;
      if (md >= 0) mem_req = 1'b0;
    end
    if_req  = 1'b0;
    mem_req = 1'b0;
    bus_ack = 1'b0;
    check("tie_first_addr", a1, 32'h1001_0000);
    check("tie_mem_done_cycle", 32'(md), 32'd2);
    check("tie_mem_rdata", mrd, ~32'h1001_0000);
    check("tie_stalls_c2", 32'(s2), 32'b10);
    check("tie_second_addr", a4, 32'h0040_0000);
    check("tie_if_done_cycle", 32'(id), 32'd5);
    check("tie_if_rdata", ird, ~32'h0040_0000);
    @(posedge clk);
    #1;

    // Asynchronous reset while a load waits on the bus
    mem_req   = 1'b1;
    mem_we    = 1'b0;
    mem_be    = 4'hF;
    mem_addr  = 32'h1001_0010;
    mem_wdata = 32'h7777_7777;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
    end
    check("rst_mid_bus_req_before", 32'(bus_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_ctl", 32'({bus_req, bus_we, bus_be, if_done, mem_done, if_stall, mem_stall,
                              bus_err}), 32'd0);
    check("rst_mid_payload", bus_addr | bus_wdata, 32'd0);
    check("rst_mid_rdata", if_rdata | mem_rdata, 32'd0);
    mem_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    do_txn(100, vecs[0]);

    // MEM requests back to back while a fetch waits
    mem_req   = 1'b1;
    mem_we    = 1'b0;
    mem_be    = 4'hF;
    mem_addr  = 32'h1001_0020;
    mem_wdata = '0;
    if_req    = 1'b1;
    if_addr   = 32'h0040_0010;
    n_done    = 0;
    first_if  = -1;
    for (int c = 0; c < 60 && n_done < 5; c++) begin
      @(negedge clk);
      bus_ack   = bus_req;
      bus_rdata = ~bus_addr;
      if (if_done) begin
        n_done++;
        if (first_if < 0) first_if = n_done;
      end
      if (mem_done) n_done++;
      @(posedge clk);
      #1;
    end
    mem_req = 1'b0;
    if_req  = 1'b0;
    bus_ack = 1'b0;
    check("starve_grants", 32'(n_done), 32'd5);
`ifdef PIPE_ARB_STARVE_GUARD_EN
    check("starve_first_if_grant", 32'(first_if), 32'd5);
`else
    check("starve_first_if_grant", 32'(first_if), 32'hFFFF_FFFF);
`endif
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got no end, expected end");
    $fatal(1);
  end

endmodule
